// File: rtl/apb_regif_pkg.sv
// Shared types and helpers for the APB register-file bridge.
// Optional timeout feature is enabled by defining APB_REGIF_TIMEOUT_EN.
package apb_regif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Width of the channel field in PADDR; supports up to 8 channels
    localparam int unsigned CH_FIELD_W = 3;
    localparam int unsigned MAX_CH     = 8;

    // One-hot encode a channel index over the maximum channel count
    function automatic logic [MAX_CH-1:0] onehot(input logic [CH_FIELD_W-1:0] ch);
        logic [MAX_CH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/apb_regif_rdmux.sv
// Selects read data, ack and error of the latched channel from the
// per-channel register-file response buses.
module apb_regif_rdmux
    import apb_regif_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 2
) (
    input  logic [CH_FIELD_W-1:0]    ch,
    input  logic [NUM_CH*DATA_W-1:0] regif_rdata,
    input  logic [NUM_CH-1:0]        regif_ack,
    input  logic [NUM_CH-1:0]        regif_err,
    output logic [DATA_W-1:0]        sel_rdata,
    output logic                     sel_ack,
    output logic                     sel_err
);

    // Route the selected channel; out-of-range indices yield all zeros
    always_comb begin
        sel_rdata = '0;
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_FIELD_W'(k)) begin
                sel_rdata = regif_rdata[k*DATA_W +: DATA_W];
                sel_ack   = regif_ack[k];
                sel_err   = regif_err[k];
            end
        end
    end

endmodule

// File: rtl/apb_regif_bridge.sv
// APB3 slave front-end for the UART register files. Decodes PADDR into
// NUM_CH channels, runs a req/ack handshake with wait states and returns
// registered PRDATA/PSLVERR. Define APB_REGIF_TIMEOUT_EN to abort ACCESS
// after TIMEOUT_CYC cycles without an ack.
module apb_regif_bridge
    import apb_regif_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CH_LSB      = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [31:0]              PADDR,
    input  logic [DATA_W-1:0]        PWDATA,
    output logic [DATA_W-1:0]        PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    output logic [NUM_CH-1:0]        regif_req,
    output logic                     regif_write,
    output logic [ADDR_W-1:0]        regif_addr,
    output logic [DATA_W-1:0]        regif_wdata,
    input  logic [NUM_CH*DATA_W-1:0] regif_rdata,
    input  logic [NUM_CH-1:0]        regif_ack,
    input  logic [NUM_CH-1:0]        regif_err
);

    localparam logic [CH_FIELD_W:0] NUM_CH_W = (CH_FIELD_W + 1)'(NUM_CH);

    state_e                  state_q, state_d;
    logic [CH_FIELD_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0]       req_q, req_d;
    logic                    write_q, write_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;

    logic                    setup;
    logic [CH_FIELD_W-1:0]   ch_in;
    logic [MAX_CH-1:0]       ch_in_oh;
    logic                    dec_err;
    logic [DATA_W-1:0]       sel_rdata;
    logic                    sel_ack;
    logic                    sel_err;
    logic                    timeout;
    logic                    unused_bits;

    assign setup    = PSEL & ~PENABLE;
    assign ch_in    = PADDR[CH_LSB +: CH_FIELD_W];
    assign ch_in_oh = onehot(ch_in);
    assign dec_err  = ({1'b0, ch_in} >= NUM_CH_W) || (PADDR[1:0] != 2'b00);
    // Address bits outside the decoded fields are don't-care
    assign unused_bits = ^{PADDR, ch_in_oh};

    apb_regif_rdmux #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_rdmux (
        .ch          (ch_q),
        .regif_rdata (regif_rdata),
        .regif_ack   (regif_ack),
        .regif_err   (regif_err),
        .sel_rdata   (sel_rdata),
        .sel_ack     (sel_ack),
        .sel_err     (sel_err)
    );

`ifdef APB_REGIF_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;

    // Count ACCESS cycles; held at zero elsewhere so every transfer starts fresh
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == ST_ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RESP accepts a new setup just like IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (setup) begin
                    state_d = dec_err ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (sel_ack || timeout) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and latched request fields
    always_comb begin
        req_d     = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ch_d      = ch_q;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (setup) begin
                    write_d = PWRITE;
                    addr_d  = PADDR[ADDR_W-1:0];
                    wdata_d = PWDATA;
                    ch_d    = ch_in;
                    if (dec_err) begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        req_d = ch_in_oh[NUM_CH-1:0];
                    end
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    req_d = '0;
                end else if (sel_ack) begin
                    pready_d  = 1'b1;
                    pslverr_d = sel_err;
                    // Writes and slave-error reads return zero data
                    prdata_d  = (write_q || sel_err) ? '0 : sel_rdata;
                end else if (timeout) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    req_d = req_q;
                end
            end
            default: ;
        endcase
    end

    // Output and latch registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ch_q      <= '0;
            req_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            ch_q      <= ch_d;
            req_q     <= req_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PRDATA      = prdata_q;
    assign PREADY      = pready_q;
    assign PSLVERR     = pslverr_q;
    assign regif_req   = req_q;
    assign regif_write = write_q;
    assign regif_addr  = addr_q;
    assign regif_wdata = wdata_q;

endmodule
